// File: rtl/down_sample.sv
// down_sample: multi-rate boxcar decimator.
//   Takes one signed sample per clock. Produces floor-averages of fixed,
//   non-overlapping blocks of 2, 4 and 8 consecutive samples. Blocks are
//   aligned to reset release.
//
// Ports:
//   i_clk   sole clock; all state changes on its rising edge
//   i_rst   asynchronous, active-low reset (0 = in reset)
//   i_data  signed input sample, taken on every rising edge
//   o_ds2   signed floor-average of each block of 2 samples (updates every 2nd edge)
//   o_ds4   signed floor-average of each block of 4 samples (updates every 4th edge)
//   o_ds8   signed floor-average of each block of 8 samples (updates every 8th edge)
module down_sample #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic signed [DATA_WIDTH-1:0] o_ds2,
  output logic signed [DATA_WIDTH-1:0] o_ds4,
  output logic signed [DATA_WIDTH-1:0] o_ds8
);

  logic        [2:0]            cnt;
  logic signed [DATA_WIDTH:0]   acc2;
  logic signed [DATA_WIDTH+1:0] acc4;
  logic signed [DATA_WIDTH+2:0] acc8;

  logic signed [DATA_WIDTH:0]   sum2;
  logic signed [DATA_WIDTH+1:0] sum4;
  logic signed [DATA_WIDTH+2:0] sum8;

  logic end2;
  logic end4;
  logic end8;

  // Accumulator plus the current sample, with i_data sign-extended to each width.
  always_comb begin
    sum2 = acc2 + {{1{i_data[DATA_WIDTH-1]}}, i_data};
    sum4 = acc4 + {{2{i_data[DATA_WIDTH-1]}}, i_data};
    sum8 = acc8 + {{3{i_data[DATA_WIDTH-1]}}, i_data};
  end

  // A block ends when the low log2(N) phase bits are all ones.
  always_comb begin
    end2 = cnt[0];
    end4 = &cnt[1:0];
    end8 = &cnt;
  end

  // Taking bits [W+k-1:k] of the sum is the arithmetic shift by k followed by
  // truncation to DATA_WIDTH; the mean always fits, so the dropped MSBs are
  // pure sign copies.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt   <= '0;
      acc2  <= '0;
      acc4  <= '0;
      acc8  <= '0;
      o_ds2 <= '0;
      o_ds4 <= '0;
      o_ds8 <= '0;
    end else begin
      cnt <= cnt + 3'd1;

      if (end2) begin
        o_ds2 <= sum2[DATA_WIDTH:1];
        acc2  <= '0;
      end else begin
        acc2  <= sum2;
      end

      if (end4) begin
        o_ds4 <= sum4[DATA_WIDTH+1:2];
        acc4  <= '0;
      end else begin
        acc4  <= sum4;
      end

      if (end8) begin
        o_ds8 <= sum8[DATA_WIDTH+2:3];
        acc8  <= '0;
      end else begin
        acc8  <= sum8;
      end
    end
  end

endmodule

// File: tb/tb_down_sample.sv
module tb_down_sample;

  localparam int DW = 16;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic signed [DW-1:0] i_data;
  logic signed [DW-1:0] o_ds2;
  logic signed [DW-1:0] o_ds4;
  logic signed [DW-1:0] o_ds8;

  always #5 i_clk = ~i_clk;

  down_sample #(.DATA_WIDTH(DW)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .o_ds2  (o_ds2),
    .o_ds4  (o_ds4),
    .o_ds8  (o_ds8)
  );

  typedef struct {
    int e2;
    int e4;
    int e8;
  } exp_t;

  exp_t sbq[$];
  int   hist[$];     // samples seen since the last reset release
  int   cur2 = 0;
  int   cur4 = 0;
  int   cur8 = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Mathematical floor of the mean of the last n samples.
  function automatic int floor_avg(input int n);
    int s = 0;
    int q;
    for (int k = hist.size() - n; k < hist.size(); k++) s += hist[k];
    q = s / n;
    if ((s % n != 0) && (s < 0)) q -= 1;
    return q;
  endfunction

  // Drive one sample (or reset cycle) and record the expected outputs after the edge.
  task automatic step(input logic rst_n, input int d);
    exp_t e;
    @(negedge i_clk);
    i_rst  = rst_n;
    i_data = d[DW-1:0];
    if (!rst_n) begin
      hist.delete();
      cur2 = 0;
      cur4 = 0;
      cur8 = 0;
      #1;
      check("async_rst_ds2", int'(o_ds2), 0);
      check("async_rst_ds4", int'(o_ds4), 0);
      check("async_rst_ds8", int'(o_ds8), 0);
    end else begin
      hist.push_back(d);
      if (hist.size() % 2 == 0) cur2 = floor_avg(2);
      if (hist.size() % 4 == 0) cur4 = floor_avg(4);
      if (hist.size() % 8 == 0) cur8 = floor_avg(8);
    end
    e.e2 = cur2;
    e.e4 = cur4;
    e.e8 = cur8;
    sbq.push_back(e);
  endtask

  // Monitor: the outputs are registered, so each edge presents one result triple.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sb_ds2", int'(o_ds2), e.e2);
        check("sb_ds4", int'(o_ds4), e.e4);
        check("sb_ds8", int'(o_ds8), e.e8);
      end
    end
  end

  task automatic after_edge;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic signed [DW-1:0] r;
    int d;
    i_rst  = 1'b0;
    i_data = 16'sd1234;

    // Held in reset while clocking.
    repeat (4) step(1'b0, 1234);

    // Constant input after release.
    repeat (16) step(1'b1, 100);
    after_edge();
    check("const_ds2", int'(o_ds2), 100);
    check("const_ds4", int'(o_ds4), 100);
    check("const_ds8", int'(o_ds8), 100);

    // Ramp 0..7 aligned to a fresh release.
    step(1'b0, 0);
    for (int k = 0; k < 8; k++) step(1'b1, k);
    after_edge();
    check("ramp_ds2", int'(o_ds2), 6);
    check("ramp_ds4", int'(o_ds4), 5);
    check("ramp_ds8", int'(o_ds8), 3);

    // Negative floor rounding.
    step(1'b0, 0);
    step(1'b1, -3);
    step(1'b1, -4);
    after_edge();
    check("neg_ds2", int'(o_ds2), -4);
    step(1'b0, 0);
    step(1'b1, -1);
    step(1'b1, -1);
    step(1'b1, -1);
    step(1'b1, -2);
    after_edge();
    check("neg_ds4", int'(o_ds4), -2);

    // Full-scale extremes.
    step(1'b0, 0);
    repeat (8) step(1'b1, 32767);
    after_edge();
    check("max_ds8", int'(o_ds8), 32767);
    check("max_ds2", int'(o_ds2), 32767);
    repeat (8) step(1'b1, -32768);
    after_edge();
    check("min_ds8", int'(o_ds8), -32768);
    check("min_ds4", int'(o_ds4), -32768);

    // Reset mid-block, then realignment from release.
    step(1'b0, 0);
    repeat (5) step(1'b1, 50);
    step(1'b0, 50);
    step(1'b0, 10);
    repeat (7) step(1'b1, 10);
    after_edge();
    check("rst_mid_ds8_early", int'(o_ds8), 0);
    step(1'b1, 10);
    after_edge();
    check("rst_mid_ds8", int'(o_ds8), 10);

    // Randomized traffic with occasional resets and extreme values.
    for (int k = 0; k < 800; k++) begin
      r = 16'($urandom);
      d = int'(r);
      case ($urandom_range(0, 9))
        0: d = 32767;
        1: d = -32768;
        default: ;
      endcase
      step(($urandom_range(0, 59) != 0), d);
    end

    repeat (2) @(posedge i_clk);
    #3;
    check("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
